// File: rtl/cte_pkg.sv
// Shared definitions for the colour transform engine.
// Coefficients, rounding offsets, encoder states and clamp.
package cte_pkg;

  localparam logic signed [17:0] YR = 18'sd77;
  localparam logic signed [17:0] YG = 18'sd150;
  localparam logic signed [17:0] YB = 18'sd29;
  localparam logic signed [17:0] UR = 18'sd43;
  localparam logic signed [17:0] UG = 18'sd85;
  localparam logic signed [17:0] UB = 18'sd128;
  localparam logic signed [17:0] VR = 18'sd128;
  localparam logic signed [17:0] VG = 18'sd107;
  localparam logic signed [17:0] VB = 18'sd21;
  localparam logic signed [17:0] Y_OFS  = 18'sd128;
  localparam logic signed [17:0] UV_OFS = 18'sd32896;

  typedef enum logic [2:0] {
    PIX0,
    PIX1,
    CALC,
    EMIT_U,
    EMIT_Y0,
    EMIT_V,
    EMIT_Y1
  } state_t;

  function automatic logic [7:0] clamp8(
    input logic signed [17:0] x
  );
    logic signed [17:0] s;
    s = x >>> 8;
    if (s < 18'sd0)
      return 8'd0;
    else if (s > 18'sd255)
      return 8'd255;
    else
      return s[7:0];
  endfunction

endpackage

// File: rtl/rgb2yuv_pix.sv
// One-pixel RGB to Y/U/V converter, combinational.
// Sums are signed 18-bit; results clamp to 0..255.
module rgb2yuv_pix
  import cte_pkg::*;
(
  input  logic [23:0] rgb,
  output logic [7:0]  y,
  output logic [7:0]  u,
  output logic [7:0]  v
);

  logic signed [17:0] r;
  logic signed [17:0] g;
  logic signed [17:0] b;
  logic signed [17:0] sy;
  logic signed [17:0] su;
  logic signed [17:0] sv;

  assign r = $signed({10'd0, rgb[23:16]});
  assign g = $signed({10'd0, rgb[15:8]});
  assign b = $signed({10'd0, rgb[7:0]});

  assign sy = YR * r + YG * g + YB * b + Y_OFS;
  assign su = UB * b - UR * r - UG * g + UV_OFS;
  assign sv = VR * r - VG * g - VB * b + UV_OFS;

  // U/V can land on 256 for saturated blue/red.
  assign y = clamp8(sy);
  assign u = clamp8(su);
  assign v = clamp8(sv);

endmodule

// File: rtl/rgb2yuv_enc.sv
// RGB to YUV 4:2:2 encoder: pixel pairs in, U,Y0,V,Y1 bytes out.
// Same in_en/busy handshake as the decode path.
module rgb2yuv_enc
  import cte_pkg::*;
#(
  parameter int CHROMA_AVG = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_en,
  input  logic [23:0] rgb_in,
  output logic        busy,
  output logic        out_valid,
  output logic [7:0]  yuv_out
);

  state_t state;
  state_t state_n;

  logic [23:0] p0;
  logic [23:0] p1;
  logic [7:0]  y0_r;
  logic [7:0]  y1_r;
  logic [7:0]  v_r;

  logic [7:0] y0;
  logic [7:0] u0;
  logic [7:0] v0;
  logic [7:0] y1;
  logic [7:0] u1;
  logic [7:0] v1;

  logic [8:0] u_sum;
  logic [8:0] v_sum;
  logic [7:0] u_sel;
  logic [7:0] v_sel;

  logic       ld0;
  logic       ld1;
  logic       busy_n;
  logic       valid_n;
  logic [7:0] byte_n;

  rgb2yuv_pix u_pix0 (
    .rgb (p0),
    .y   (y0),
    .u   (u0),
    .v   (v0)
  );

  rgb2yuv_pix u_pix1 (
    .rgb (p1),
    .y   (y1),
    .u   (u1),
    .v   (v1)
  );

  assign u_sum = {1'b0, u0} + {1'b0, u1} + 9'd1;
  assign v_sum = {1'b0, v0} + {1'b0, v1} + 9'd1;

  assign u_sel = (CHROMA_AVG != 0) ? u_sum[8:1] : u0;
  assign v_sel = (CHROMA_AVG != 0) ? v_sum[8:1] : v0;

  // U goes straight to the output register on leaving CALC.
  always_comb begin
    state_n = state;
    ld0     = 1'b0;
    ld1     = 1'b0;
    valid_n = 1'b0;
    byte_n  = yuv_out;
    unique case (state)
      PIX0: begin
        if (in_en) begin
          ld0     = 1'b1;
          state_n = PIX1;
        end
      end
      PIX1: begin
        if (in_en) begin
          ld1     = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        state_n = EMIT_U;
        valid_n = 1'b1;
        byte_n  = u_sel;
      end
      EMIT_U: begin
        state_n = EMIT_Y0;
        valid_n = 1'b1;
        byte_n  = y0_r;
      end
      EMIT_Y0: begin
        state_n = EMIT_V;
        valid_n = 1'b1;
        byte_n  = v_r;
      end
      EMIT_V: begin
        state_n = EMIT_Y1;
        valid_n = 1'b1;
        byte_n  = y1_r;
      end
      EMIT_Y1: begin
        if (in_en) begin
          ld0     = 1'b1;
          state_n = PIX1;
        end else begin
          state_n = PIX0;
        end
      end
      default: state_n = PIX0;
    endcase
  end

  always_comb begin
    busy_n = 1'b0;
    unique case (state_n)
      CALC, EMIT_U, EMIT_Y0, EMIT_V: busy_n = 1'b1;
      default:                       busy_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PIX0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      yuv_out   <= 8'h00;
      p0        <= 24'd0;
      p1        <= 24'd0;
      y0_r      <= 8'd0;
      y1_r      <= 8'd0;
      v_r       <= 8'd0;
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      out_valid <= valid_n;
      yuv_out   <= byte_n;
      if (ld0)
        p0 <= rgb_in;
      if (ld1)
        p1 <= rgb_in;
      if (state == CALC) begin
        y0_r <= y0;
        y1_r <= y1;
        v_r  <= v_sel;
      end
    end
  end

endmodule

// File: tb/tb_rgb2yuv_enc.sv
// Directed bench for rgb2yuv_enc, averaged and pixel-0 chroma.
// Immediate assertions at each check; one summary line at the end.
module tb_rgb2yuv_enc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [23:0] rgb_in;
  logic        busy;
  logic        out_valid;
  logic [7:0]  yuv_out;
  logic        busy0;
  logic        out_valid0;
  logic [7:0]  yuv_out0;

  int passed = 0;
  int total  = 0;

  logic [7:0]  q[$];
  logic [7:0]  q0[$];
  logic [23:0] px[500];

  always #5 clk = ~clk;

  rgb2yuv_enc #(.CHROMA_AVG(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .rgb_in    (rgb_in),
    .busy      (busy),
    .out_valid (out_valid),
    .yuv_out   (yuv_out)
  );

  rgb2yuv_enc #(.CHROMA_AVG(0)) dut0 (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .rgb_in    (rgb_in),
    .busy      (busy0),
    .out_valid (out_valid0),
    .yuv_out   (yuv_out0)
  );

  always @(negedge clk) begin
    if (out_valid)
      q.push_back(yuv_out);
    if (out_valid0)
      q0.push_back(yuv_out0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat(input int x);
    int s;
    s = x >>> 8;
    if (s < 0)
      return 8'd0;
    if (s > 255)
      return 8'd255;
    return s[7:0];
  endfunction

  function automatic logic [31:0] model(input logic [23:0] a,
                                        input logic [23:0] b,
                                        input bit avg);
    int ra, ga, ba, rb, gb, bb;
    int ua, ub, va, vb, u, v;
    ra = int'(a[23:16]); ga = int'(a[15:8]); ba = int'(a[7:0]);
    rb = int'(b[23:16]); gb = int'(b[15:8]); bb = int'(b[7:0]);
    ua = int'(sat(-43 * ra - 85 * ga + 128 * ba + 32896));
    ub = int'(sat(-43 * rb - 85 * gb + 128 * bb + 32896));
    va = int'(sat(128 * ra - 107 * ga - 21 * ba + 32896));
    vb = int'(sat(128 * rb - 107 * gb - 21 * bb + 32896));
    u = avg ? (ua + ub + 1) / 2 : ua;
    v = avg ? (va + vb + 1) / 2 : va;
    return {u[7:0], sat(77 * ra + 150 * ga + 29 * ba + 128),
            v[7:0], sat(77 * rb + 150 * gb + 29 * bb + 128)};
  endfunction

  task automatic push(input logic [23:0] p);
    int n;
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50)
      chk("push_timeout", 32'd1, 32'd0);
    in_en  = 1'b1;
    rgb_in = p;
    @(negedge clk);
    in_en  = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int c;
    c = 0;
    while ((q.size() < n || q0.size() < n) && c < limit) begin
      @(negedge clk);
      c++;
    end
    #1;
    if (q.size() < n || q0.size() < n)
      chk("byte_timeout", q.size(), n);
  endtask

  task automatic check_pair(input string tag, input logic [31:0] e1,
                            input logic [31:0] e0);
    logic [7:0] b;
    wait_bytes(4, 40);
    for (int i = 0; i < 4; i++) begin
      b = (q.size() > 0) ? q.pop_front() : 8'hxx;
      chk($sformatf("%s_avg_b%0d", tag, i), b, e1[31-8*i -: 8]);
      b = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
      chk($sformatf("%s_p0_b%0d", tag, i), b, e0[31-8*i -: 8]);
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int it;
    logic [31:0] e1;
    logic [31:0] e0;
    logic [7:0]  b;

    reset  = 1'b1;
    in_en  = 1'b0;
    rgb_in = 24'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_yuv", yuv_out, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    push(24'hFFFFFF);
    push(24'hFFFFFF);
    check_pair("white", 32'h80FF80FF, 32'h80FF80FF);

    push(24'h000000);
    push(24'h000000);
    check_pair("black", 32'h80008000, 32'h80008000);

    push(24'h0000FF);
    push(24'h0000FF);
    check_pair("blue", 32'hFF1D6B1D, 32'hFF1D6B1D);

    push(24'hFF0000);
    push(24'h0000FF);
    chk("lat_calc_busy", busy, 1'b1);
    chk("lat_calc_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("lat_u_valid", out_valid, 1'b1);
    chk("lat_u_byte", yuv_out, 8'hAA);
    check_pair("redblue", 32'hAA4DB51D, 32'h554DFF1D);

    push(24'hFF0000);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("gap_busy%0d", i), busy, 1'b0);
      chk($sformatf("gap_valid%0d", i), out_valid, 1'b0);
      @(negedge clk);
    end
    push(24'h0000FF);
    check_pair("gap", 32'hAA4DB51D, 32'h554DFF1D);

    push(24'hFF0000);
    push(24'h0000FF);
    repeat (3) @(negedge clk);
    chk("mid_v_valid", out_valid, 1'b1);
    chk("mid_v_byte", yuv_out, 8'hB5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_yuv", yuv_out, 8'h00);
    #1;
    q.delete();
    q0.delete();
    @(negedge clk);
    push(24'hFFFFFF);
    push(24'hFFFFFF);
    check_pair("post_rst", 32'h80FF80FF, 32'h80FF80FF);
    repeat (10) @(negedge clk);
    chk("no_stale", q.size(), 0);

    for (int i = 0; i < 500; i++)
      px[i] = 24'($urandom);
    px[0] = 24'hFF0000;
    px[1] = 24'h0000FF;
    k  = 0;
    it = 0;
    while (k < 500 && it < 5000) begin
      it++;
      in_en = 1'b1;
      if (!busy) begin
        rgb_in = px[k];
        k++;
      end else begin
        rgb_in = 24'($urandom);
      end
      @(negedge clk);
    end
    in_en = 1'b0;
    chk("stream_cycles", it, 1496);
    wait_bytes(1000, 200);
    repeat (10) @(negedge clk);
    chk("stream_count", q.size(), 1000);
    chk("stream_count0", q0.size(), 1000);
    for (int p = 0; p < 250; p++) begin
      e1 = model(px[2*p], px[2*p+1], 1'b1);
      e0 = model(px[2*p], px[2*p+1], 1'b0);
      for (int i = 0; i < 4; i++) begin
        b = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk($sformatf("stream_avg_p%0d_b%0d", p, i), b, e1[31-8*i -: 8]);
        b = (q0.size() > 0) ? q0.pop_front() : 8'hxx;
        chk($sformatf("stream_p0_p%0d_b%0d", p, i), b, e0[31-8*i -: 8]);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
